// File: rtl/pc_sequencer.sv
// Program counter and run control: start/done handshake, problem select latch,
// next-PC selection (increment / absolute jump) and a RUN-cycle watchdog.
module pc_sequencer #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned START0  = 0,
  parameter int unsigned START1  = 128,
  parameter int unsigned START2  = 256,
  parameter logic [15:0] MAX_CYC = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      problem_in,
  input  logic            branch_taken,
  input  logic [7:0]      jump_target,
  input  logic            halt,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      problem,
  output logic            running,
  output logic            done,
  output logic            timeout,
  output logic [15:0]     cyc_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [1:0]      problem;
    logic [15:0]     cyc;
    logic            timeout;
  } ctx_t;

  localparam logic [15:0] CYC_LIM = MAX_CYC - 16'd1;

  state_t state, state_nxt;
  ctx_t   ctx, ctx_nxt;

  logic            start_ok;
  logic [PC_W-1:0] start_pc;
  logic [PC_W-1:0] jump_pc;
  logic [15:0]     cyc_inc;

  assign start_ok = start && (problem_in != 2'd3);
  assign jump_pc  = {{(PC_W-8){1'b0}}, jump_target};
  // Saturate rather than wrap so a long run never reports a small count.
  assign cyc_inc  = (ctx.cyc == 16'hFFFF) ? ctx.cyc : ctx.cyc + 16'd1;

  always_comb begin
    start_pc = PC_W'(START0);
    case (problem_in)
      2'd1:    start_pc = PC_W'(START1);
      2'd2:    start_pc = PC_W'(START2);
      default: start_pc = PC_W'(START0);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctx   <= '0;
    end else begin
      state <= state_nxt;
      ctx   <= ctx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctx_nxt   = ctx;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_nxt       = RUN;
          ctx_nxt.pc      = start_pc;
          ctx_nxt.problem = problem_in;
          ctx_nxt.cyc     = 16'd0;
          ctx_nxt.timeout = 1'b0;
        end
      end
      RUN: begin
        ctx_nxt.cyc = cyc_inc;
        // halt outranks the watchdog; stall outranks a taken branch.
        if (halt) begin
          state_nxt       = DONE;
          ctx_nxt.timeout = 1'b0;
        end else if (ctx.cyc == CYC_LIM) begin
          state_nxt       = DONE;
          ctx_nxt.timeout = 1'b1;
        end else if (stall) begin
          ctx_nxt.pc = ctx.pc;
        end else if (branch_taken) begin
          ctx_nxt.pc = jump_pc;
        end else begin
          ctx_nxt.pc = ctx.pc + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc        = ctx.pc;
  assign problem   = ctx.problem;
  assign cyc_count = ctx.cyc;
  assign timeout   = ctx.timeout;
  assign running   = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer; a cycle-level behavioural model
// tracks two instances (default watchdog and a short 20-cycle watchdog).
module tb_pc_sequencer;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic [1:0] problem_in = 0;
  logic       branch_taken = 0;
  logic [7:0] jump_target = 0;
  logic       halt = 0;
  logic       stall = 0;

  logic [9:0]  pc_a, pc_b;
  logic [1:0]  prob_a, prob_b;
  logic        run_a, run_b, done_a, done_b, tmo_a, tmo_b;
  logic [15:0] cyc_a, cyc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .problem_in(problem_in),
    .branch_taken(branch_taken), .jump_target(jump_target), .halt(halt), .stall(stall),
    .pc(pc_a), .problem(prob_a), .running(run_a), .done(done_a), .timeout(tmo_a),
    .cyc_count(cyc_a));

  pc_sequencer #(.MAX_CYC(16'd20)) dut_wd (
    .clk(clk), .rst(rst), .start(start), .problem_in(problem_in),
    .branch_taken(branch_taken), .jump_target(jump_target), .halt(halt), .stall(stall),
    .pc(pc_b), .problem(prob_b), .running(run_b), .done(done_b), .timeout(tmo_b),
    .cyc_count(cyc_b));

  // Model: mode 0 = idle, 1 = executing, 2 = finished.
  typedef struct {
    int mode;
    int pc;
    int prob;
    int cyc;
    int tmo;
  } mdl_t;

  mdl_t ma, mb;
  mdl_t zero_m = '{0, 0, 0, 0, 0};

  function automatic mdl_t advance(mdl_t m, int limit, int st, int pin, int bt,
                                   int jt, int hl, int sl);
    mdl_t n = m;
    if (m.mode != 1) begin
      if (st != 0 && pin != 3) begin
        n.mode = 1; n.prob = pin; n.pc = pin * 128; n.cyc = 0; n.tmo = 0;
      end
    end else begin
      n.cyc = (m.cyc >= 65535) ? 65535 : m.cyc + 1;
      if (hl != 0) begin
        n.mode = 2; n.tmo = 0;
      end else if (m.cyc + 1 == limit) begin
        n.mode = 2; n.tmo = 1;
      end else if (sl != 0) begin
        n.pc = m.pc;
      end else if (bt != 0) begin
        n.pc = jt;
      end else begin
        n.pc = (m.pc + 1) % 1024;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= zero_m;
      mb <= zero_m;
    end else begin
      ma <= advance(ma, 65535, int'(start), int'(problem_in), int'(branch_taken),
                    int'(jump_target), int'(halt), int'(stall));
      mb <= advance(mb, 20, int'(start), int'(problem_in), int'(branch_taken),
                    int'(jump_target), int'(halt), int'(stall));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a.pc", int'(pc_a), ma.pc);
    chk("a.problem", int'(prob_a), ma.prob);
    chk("a.running", int'(run_a), int'(ma.mode == 1));
    chk("a.done", int'(done_a), int'(ma.mode == 2));
    chk("a.timeout", int'(tmo_a), ma.tmo);
    chk("a.cyc_count", int'(cyc_a), ma.cyc);
    chk("b.pc", int'(pc_b), mb.pc);
    chk("b.problem", int'(prob_b), mb.prob);
    chk("b.running", int'(run_b), int'(mb.mode == 1));
    chk("b.done", int'(done_b), int'(mb.mode == 2));
    chk("b.timeout", int'(tmo_b), mb.tmo);
    chk("b.cyc_count", int'(cyc_b), mb.cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 0; branch_taken = 0; halt = 0; stall = 0;
  endtask

  initial begin
    repeat (2) step();
    chk("reset.pc", int'(pc_a), 0);
    chk("reset.done", int'(done_a), 0);
    rst = 0;
    step();

    // Problem 0, halt at pc=5.
    start = 1; problem_in = 0; step();
    chk("p0.first_pc", int'(pc_a), 0);
    repeat (5) step();
    chk("p0.pc5", int'(pc_a), 5);
    halt = 1; step();
    chk("halt.pc", int'(pc_a), 5);
    chk("halt.done", int'(done_a), 1);
    chk("halt.timeout", int'(tmo_a), 0);
    chk("halt.cyc", int'(cyc_a), 6);

    // Problem 2, branch at 260.
    start = 1; problem_in = 2; step();
    chk("p2.first_pc", int'(pc_a), 256);
    repeat (4) step();
    branch_taken = 1; jump_target = 8'd86; step();
    chk("br.pc", int'(pc_a), 86);
    step();
    chk("br.pc_next", int'(pc_a), 87);

    // Stall + branch at pc=300.
    halt = 1; step();
    start = 1; problem_in = 2; step();
    repeat (44) step();
    chk("st.pc300", int'(pc_a), 300);
    stall = 1; branch_taken = 1; jump_target = 8'd24; step();
    chk("st.hold", int'(pc_a), 300);
    branch_taken = 1; jump_target = 8'd24; step();
    chk("st.jump", int'(pc_a), 24);

    // Halt + branch, then invalid and valid restarts from DONE.
    halt = 1; branch_taken = 1; jump_target = 8'd99; step();
    chk("hb.pc", int'(pc_a), 24);
    chk("hb.done", int'(done_a), 1);
    start = 1; problem_in = 3; step();
    chk("inv.done", int'(done_a), 1);
    chk("inv.running", int'(run_a), 0);
    start = 1; problem_in = 1; step();
    chk("p1.pc", int'(pc_a), 128);
    chk("p1.done", int'(done_a), 0);
    chk("p1.problem", int'(prob_a), 1);

    // Watchdog on the short instance; a start mid-run is ignored.
    halt = 1; step();
    start = 1; problem_in = 0; step();
    repeat (4) step();
    start = 1; problem_in = 2; step();
    repeat (14) step();
    chk("wd.pre_running", int'(run_b), 1);
    chk("wd.pre_pc", int'(pc_b), 19);
    step();
    chk("wd.done", int'(done_b), 1);
    chk("wd.timeout", int'(tmo_b), 1);
    chk("wd.cyc", int'(cyc_b), 20);
    chk("wd.pc", int'(pc_b), 19);
    chk("wd.problem", int'(prob_b), 0);

    // Async reset mid-run at pc=37 on the default instance.
    repeat (17) step();
    chk("rr.pc37", int'(pc_a), 37);
    #2 rst = 1;
    #1;
    chk("rr.pc", int'(pc_a), 0);
    chk("rr.running", int'(run_a), 0);
    chk("rr.cyc", int'(cyc_a), 0);
    chk("rr.done", int'(done_a), 0);
    step();
    rst = 0;
    step();
    start = 1; problem_in = 1; step();
    chk("rr.restart_pc", int'(pc_a), 128);
    chk("rr.restart_prob", int'(prob_a), 1);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      start        = ($urandom_range(0, 11) == 0);
      problem_in   = 2'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 3) == 0);
      jump_target  = 8'($urandom);
      halt         = ($urandom_range(0, 79) == 0);
      stall        = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
    end
    start = 0; branch_taken = 0; halt = 0; stall = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and run-control stage directly downstream of the branch jump-target lookup.
- Holds the PC for the instruction memory and selects the next PC each cycle:
  - increment, or
  - absolute jump to the 8-bit lookup target when a branch is taken.
- Owns the per-program start/done handshake with the testbench/top level, latches the active problem select fed back to the lookup, and enforces a cycle-budget watchdog.

Parameters:
- PC_W, 10, PC width in bits; the 8-bit jump target is zero-extended to PC_W.
- START0, 0, PC start address for problem 0.
- START1, 128, PC start address for problem 1.
- START2, 256, PC start address for problem 2.
- MAX_CYC, 16'hFFFF, watchdog limit on RUN cycles before forced stop.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a program.
- problem_in  in  2  program select sampled with start; 3 is invalid.
- branch_taken  in  1  decoder/ALU indicates taken branch this cycle.
- jump_target  in  8  absolute target from the branch lookup stage.
- halt  in  1  decoder indicates halt instruction at current PC.
- stall  in  1  freeze PC this cycle.
- pc  out  PC_W  current instruction address.
- problem  out  2  latched program select, drives the lookup's problem input.
- running  out  1  high while in RUN.
- done  out  1  high in DONE, held until next accepted start.
- timeout  out  1  high in DONE if entered by watchdog.
- cyc_count  out  16  RUN cycles elapsed for current/last program.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pc=0; problem=0; running=0; done=0; timeout=0; cyc_count=0.
  - Reset mid-RUN aborts with no done indication.
- FSM states: IDLE, RUN, DONE; all registers update on rising Clk.
- IDLE:
  - start=1 with problem_in in {0,1,2}: next cycle state=RUN, problem=problem_in, pc=START<problem_in>, cyc_count=0, done=0, timeout=0.
  - start with problem_in=3: ignored, stay IDLE.
- RUN, every cycle:
  - cyc_count+1.
  - Next PC priority, highest first:
    1. halt: pc holds; next state DONE; done=1 next cycle; timeout=0.
    2. cyc_count==MAX_CYC-1: pc holds; next state DONE; done=1; timeout=1.
    3. stall: pc holds; branch_taken ignored (decoder must re-present it).
    4. branch_taken: pc = {0, jump_target}.
    5. else pc = pc+1, wrapping mod 2^PC_W.
  - halt+branch_taken same cycle: halt wins, pc unchanged.
  - halt+stall: halt wins.
  - start while RUN: ignored.
- DONE:
  - pc, problem, cyc_count frozen; running=0; done=1.
  - start with valid problem_in: same transition as from IDLE, clearing done/timeout on the next edge.
  - start with problem_in=3: ignored.
- Outputs are registered; running = (state==RUN).
- Latency:
  - start to first fetch PC valid: 1 cycle.
  - branch_taken to target on pc: 1 cycle.
  - halt to done: 1 cycle.
- cyc_count counts RUN cycles including the halting cycle; saturates at 16'hFFFF and never wraps.

Test Plan:
- Reset mid-RUN at pc=37: all outputs 0 immediately (async, before next edge), state IDLE; later start with problem_in=1 -> pc=128, problem=1.
- start with problem_in=0, no branches, halt asserted at pc=5 -> pc 0,1,2,3,4,5 then hold; done=1, timeout=0, cyc_count=6 the cycle after halt.
- problem=2 running, branch_taken with jump_target=86 at pc=260 -> next pc=86; next cycle (no branch) pc=87.
- stall and branch_taken both high at pc=300 (jump_target=24) -> pc stays 300; the following cycle, branch_taken alone -> pc=24.
- halt and branch_taken same cycle -> pc unchanged, done=1; start with problem_in=3 in DONE -> ignored, done stays 1; start with problem_in=1 -> pc=128, done=0.
- MAX_CYC=20, no halt -> done=1 and timeout=1 after 20 RUN cycles, cyc_count=20, pc frozen at START+19; start while RUN earlier in the run -> no effect.
